alu_share_arbiter: RTL

//   Shares one combinational 32-bit ALU between two requesters (port 0, port 1).

---
 rtl/alu_share_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two ports.
// Operands are registered before the ALU and the result is registered after it.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;
  logic             r_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_result;

  logic             w_grant;
  logic             w_accept;
  logic             w_done;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_resp_valid;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [OPW-1:0]   w_op;

  // Both valid: the priority pointer decides; otherwise the lone requester.
  assign w_grant = (req_valid == 2'b11) ? r_prio : req_valid[1];

  assign w_a  = w_grant ? req_a1  : req_a0;
  assign w_b  = w_grant ? req_b1  : req_b0;
  assign w_op = w_grant ? req_op1 : req_op0;

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_req_ready  = 2'b00;
    w_resp_valid = 2'b00;
    unique case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_accept             = 1'b1;
          w_req_ready[w_grant] = 1'b1;
          w_state_nxt          = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        w_resp_valid[r_grant] = 1'b1;
        if (resp_ready[r_grant]) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_prio   <= 1'b0;
      r_grant  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_grant <= w_grant;
        r_a     <= w_a;
        r_b     <= w_b;
        r_op    <= w_op;
      end
      if (r_state == EXEC) begin
        r_result <= alu_result;
      end
      if (w_done) begin
        r_prio <= ~r_grant;
      end
    end
  end

  // Handshake outputs are masked while reset is held so nothing leaks out.
  assign req_ready   = reset_n ? w_req_ready  : 2'b00;
  assign resp_valid  = reset_n ? w_resp_valid : 2'b00;
  assign busy        = reset_n && (r_state != IDLE);
  assign resp_result = r_result;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_ctrl    = r_op;

endmodule
